// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/branch path: data width, branch condition
// codes and the fetch/execute state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] BEQ = 3'b000;
    localparam logic [2:0] BNE = 3'b001;
    localparam logic [2:0] BLT = 3'b100;
    localparam logic [2:0] BGE = 3'b101;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from funct3 and the ALU zero/sign flags.
// Codes outside BEQ/BNE/BLT/BGE never take the branch.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero_flag,
    input  logic       sign_flag,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (funct3)
            BEQ:     cond_true = zero_flag;
            BNE:     cond_true = ~zero_flag;
            BLT:     cond_true = sign_flag;
            BGE:     cond_true = ~sign_flag;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with two-state fetch/execute sequencing, branch/jump redirect
// and fetch timeout. Define MISALIGN_TRAP_EN to trap on misaligned targets.
module pc_branch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR  = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR   = 32'h0000_0100,
    parameter int              FETCH_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            fetch_req,
    output logic [XLEN-1:0] fetch_addr,
    input  logic            fetch_ack,
    input  logic            ex_valid,
    input  logic            branch,
    input  logic            jump,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] imm_ext,
    input  logic            zero_flag,
    input  logic            sign_flag,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            taken,
    output logic            trap,
    output logic            fetch_err
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int              CNT_W        = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    state_e          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic            taken_reg, taken_next;
    logic            trap_reg, trap_next;
    logic            err_reg, err_next;

    logic            cond_true;
    logic            redirect;
    logic            misaligned;
    logic            timeout_hit;
    logic [XLEN-1:0] target;

    branch_cond u_branch_cond (
        .funct3    (funct3),
        .zero_flag (zero_flag),
        .sign_flag (sign_flag),
        .cond_true (cond_true)
    );

    assign target      = pc_reg + imm_ext;
    assign redirect    = jump | (branch & cond_true);
    assign misaligned  = TRAP_EN && (target[1:0] != 2'b00);
    assign timeout_hit = (state_reg == FETCH) && !fetch_ack && (cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:   if (fetch_ack) state_next = EXEC;
            EXEC:    if (ex_valid)  state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        fetch_req  = (state_reg == FETCH);
        fetch_addr = pc_reg;
    end

    // An ack coincident with the last timeout cycle wins over the timeout.
    always_comb begin
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        taken_next = 1'b0;
        trap_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            FETCH: begin
                if (fetch_ack) begin
                    cnt_next = '0;
                end else if (timeout_hit) begin
                    cnt_next = '0;
                    err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            EXEC: begin
                cnt_next = '0;
                if (ex_valid) begin
                    if (redirect && misaligned) begin
                        pc_next   = TRAP_VECTOR;
                        trap_next = 1'b1;
                    end else if (redirect) begin
                        pc_next    = TRAP_EN ? target : {target[XLEN-1:2], 2'b00};
                        taken_next = 1'b1;
                    end else begin
                        pc_next = pc_reg + 32'd4;
                    end
                end
            end
            default: cnt_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_VECTOR;
            cnt_reg   <= '0;
            taken_reg <= 1'b0;
            trap_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
            taken_reg <= taken_next;
            trap_reg  <= trap_next;
            err_reg   <= err_next;
        end
    end

    assign pc        = pc_reg;
    assign pc_plus4  = pc_reg + 32'd4;
    assign taken     = taken_reg;
    assign trap      = trap_reg;
    assign fetch_err = err_reg;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed vector table, hand-written
// fetch/timeout/reset/misalign sequences, then random stimulus against a model.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic        ex_valid;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic [31:0] imm_ext;
    logic        zero_flag;
    logic        sign_flag;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        trap;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] cur_pc;

    always #5 clk = ~clk;

    pc_branch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .ex_valid   (ex_valid),
        .branch     (branch),
        .jump       (jump),
        .funct3     (funct3),
        .imm_ext    (imm_ext),
        .zero_flag  (zero_flag),
        .sign_flag  (sign_flag),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .taken      (taken),
        .trap       (trap),
        .fetch_err  (fetch_err)
    );

    typedef struct {
        logic        br;
        logic        jp;
        logic [2:0]  f3;
        logic        z;
        logic        s;
        logic [31:0] start_pc;
        logic [31:0] imm;
        logic [31:0] exp_pc;
        logic        exp_taken;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_ack = 1'b0;
        ex_valid  = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        funct3    = 3'b000;
        imm_ext   = 32'h0;
        zero_flag = 1'b0;
        sign_flag = 1'b0;
    endtask

    task automatic ack_fetch();
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
    endtask

    task automatic exec_instr(input logic br, input logic jp, input logic [2:0] f3,
                              input logic z, input logic s, input logic [31:0] imm);
        ex_valid  = 1'b1;
        branch    = br;
        jump      = jp;
        funct3    = f3;
        zero_flag = z;
        sign_flag = s;
        imm_ext   = imm;
        tick();
        idle_inputs();
    endtask

    // From FETCH: accept the word, then jump to an aligned address.
    task automatic move_to(input logic [31:0] tgt);
        ack_fetch();
        chk("taken_clear", {31'b0, taken}, 32'h0);
        exec_instr(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, tgt - cur_pc);
        chk("move_pc", pc, tgt);
        cur_pc = tgt;
    endtask

    // Behavioural model state for the random phase
    bit          m_fetch;
    logic [31:0] m_pc;
    int          m_wait;

    function automatic bit cond_ok(input logic [2:0] f3, input logic z, input logic s);
        return (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && s) || (f3 == 3'd5 && !s);
    endfunction

    initial begin
        vec_t vecs[12];
        rst = 1'b1;
        idle_inputs();

        vecs[0]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_FFF0, 32'h0000_0030, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_0040, 32'hFFFF_FFF0, 32'h0000_0044, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0040, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0020, 32'h0000_0120, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0008, 32'h0000_0208, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_000C, 32'h0000_020C, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_000C, 32'h0000_0204, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0010, 32'h0000_0210, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0010, 32'h0000_0204, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0010, 32'h0000_0204, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0010, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0040, 32'h0000_0304, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_fetch_req", {31'b0, fetch_req}, 32'h1);
        chk("rst_taken", {31'b0, taken}, 32'h0);
        chk("rst_trap", {31'b0, trap}, 32'h0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
        rst = 1'b0;

        // Ack after two cycles: address held for three fetch cycles
        for (int k = 0; k < 3; k++) begin
            chk("hold_addr", fetch_addr, 32'h0);
            chk("hold_req", {31'b0, fetch_req}, 32'h1);
            if (k == 2) fetch_ack = 1'b1;
            tick();
        end
        fetch_ack = 1'b0;
        chk("exec_req_low", {31'b0, fetch_req}, 32'h0);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        chk("exec_wait_pc", pc, 32'h0);
        chk("exec_ack_ignored", {31'b0, fetch_req}, 32'h0);
        exec_instr(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_0040);
        chk("seq_pc4", pc, 32'h4);
        chk("seq_not_taken", {31'b0, taken}, 32'h0);
        chk("seq_pc_plus4", pc_plus4, 32'h8);
        $display("seq ack-after-2: pc=%08h taken=%0b", pc, taken);
        cur_pc = 32'h4;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            move_to(vecs[i].start_pc);
            ack_fetch();
            exec_instr(vecs[i].br, vecs[i].jp, vecs[i].f3, vecs[i].z, vecs[i].s, vecs[i].imm);
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_taken", i), {31'b0, taken}, {31'b0, vecs[i].exp_taken});
            chk($sformatf("vec%0d_req", i), {31'b0, fetch_req}, 32'h1);
            $display("vec %0d: start=%08h imm=%08h pc=%08h taken=%0b", i,
                     vecs[i].start_pc, vecs[i].imm, pc, taken);
            cur_pc = vecs[i].exp_pc;
        end

        // Fetch timeout: pulse after the 16th unacked cycle, request stays up
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("to_err", {31'b0, fetch_err}, (k == 16) ? 32'h1 : 32'h0);
            chk("to_req", {31'b0, fetch_req}, 32'h1);
            chk("to_addr", fetch_addr, cur_pc);
        end
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("to_rearm", {31'b0, fetch_err}, 32'h0);
        end
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        chk("to_ack_wins_err", {31'b0, fetch_err}, 32'h0);
        chk("to_ack_wins_exec", {31'b0, fetch_req}, 32'h0);
        $display("seq timeout: err pulse seen, coincident ack entered EXEC");

        // Misaligned jump target from 0x10 with offset 0x2
        exec_instr(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h10 - cur_pc);
        cur_pc = 32'h10;
        ack_fetch();
        exec_instr(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h2);
`ifdef MISALIGN_TRAP_EN
        chk("mis_pc", pc, 32'h100);
        chk("mis_trap", {31'b0, trap}, 32'h1);
        chk("mis_taken", {31'b0, taken}, 32'h0);
        cur_pc = 32'h100;
`else
        chk("mis_pc", pc, 32'h10);
        chk("mis_trap", {31'b0, trap}, 32'h0);
        chk("mis_taken", {31'b0, taken}, 32'h1);
`endif
        $display("seq misalign: pc=%08h trap=%0b taken=%0b", pc, trap, taken);
        tick();
        chk("mis_trap_clear", {31'b0, trap}, 32'h0);

        // Reset with ack pending, then reset with ex_valid in EXEC
        rst = 1'b1;
        fetch_ack = 1'b1;
        tick();
        rst = 1'b0;
        fetch_ack = 1'b0;
        chk("rstack_pc", pc, 32'h0);
        chk("rstack_req", {31'b0, fetch_req}, 32'h1);
        tick();
        chk("rstack_still_fetch", {31'b0, fetch_req}, 32'h1);
        ack_fetch();
        rst = 1'b1;
        ex_valid = 1'b1;
        jump = 1'b1;
        imm_ext = 32'h80;
        tick();
        rst = 1'b0;
        idle_inputs();
        chk("rstex_pc", pc, 32'h0);
        chk("rstex_taken", {31'b0, taken}, 32'h0);
        chk("rstex_req", {31'b0, fetch_req}, 32'h1);
        $display("seq reset-mid-transaction: pc=%08h req=%0b", pc, fetch_req);

        // Random phase against the model
        m_fetch = 1'b1;
        m_pc    = 32'h0;
        m_wait  = 0;
        for (int n = 0; n < 600; n++) begin
            bit e_taken, e_trap, e_err;
            logic [31:0] t;
            rst       = ($urandom_range(0, 99) == 0);
            fetch_ack = ($urandom_range(0, 9) == 0);
            ex_valid  = ($urandom_range(0, 2) == 0);
            branch    = 1'($urandom);
            jump      = ($urandom_range(0, 3) == 0);
            funct3    = 3'($urandom);
            zero_flag = 1'($urandom);
            sign_flag = 1'($urandom);
            imm_ext   = ($urandom_range(0, 1) == 1) ? $urandom
                                                    : 32'($urandom_range(0, 511)) - 32'd256;
            e_taken = 1'b0;
            e_trap  = 1'b0;
            e_err   = 1'b0;
            if (rst) begin
                m_pc = 32'h0;
                m_fetch = 1'b1;
                m_wait = 0;
            end else if (m_fetch) begin
                if (fetch_ack) begin
                    m_fetch = 1'b0;
                    m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait == 16) begin
                        e_err = 1'b1;
                        m_wait = 0;
                    end
                end
            end else if (ex_valid) begin
                if (jump || (branch && cond_ok(funct3, zero_flag, sign_flag))) begin
                    t = m_pc + imm_ext;
`ifdef MISALIGN_TRAP_EN
                    if (t[1:0] != 2'b00) begin
                        m_pc = 32'h100;
                        e_trap = 1'b1;
                    end else begin
                        m_pc = t;
                        e_taken = 1'b1;
                    end
`else
                    m_pc = t & 32'hFFFF_FFFC;
                    e_taken = 1'b1;
`endif
                end else begin
                    m_pc = m_pc + 32'd4;
                end
                m_fetch = 1'b1;
                m_wait = 0;
            end
            tick();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("rnd_req", {31'b0, fetch_req}, {31'b0, m_fetch});
            chk("rnd_addr", fetch_addr, m_pc);
            chk("rnd_taken", {31'b0, taken}, {31'b0, e_taken});
            chk("rnd_trap", {31'b0, trap}, {31'b0, e_trap});
            chk("rnd_err", {31'b0, fetch_err}, {31'b0, e_err});
        end
        rst = 1'b0;
        idle_inputs();
        $display("random phase: 600 cycles applied");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
